// File: rtl/demux15_stream_generic.sv
// 1:5 stream demux, one registered stage, 1-clk latency; a stalled lane backpressures all lanes.
// Optional DEMUX15_ILLEGAL_DROP_EN: sel 5..7 is dropped and counted instead of routed to lane e.
module demux15_stream_generic #(
    parameter int bit_width = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [bit_width-1:0] in_data,
    input  logic [2:0]           in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [bit_width-1:0] out_data,
    output logic [4:0]           out_valid,
    input  logic [4:0]           out_ready,
    output logic                 err_pulse,
    output logic [7:0]           err_cnt
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t               state_q, state_d;
    logic [bit_width-1:0] data_q, data_d;
    logic [4:0]           vld_q, vld_d;
    logic                 out_fire;
    logic                 accept;
    logic                 illegal;
    logic                 load;
    logic [4:0]           lane;

    // sel[2] wins over sel[1:0], mirroring the 5:1 mux tree this undoes.
    assign lane = in_sel[2] ? 5'b10000 : (5'b00001 << in_sel[1:0]);

`ifdef DEMUX15_ILLEGAL_DROP_EN
    assign illegal = in_sel[2] & (|in_sel[1:0]);
`else
    assign illegal = 1'b0;
`endif

    assign out_fire = |(vld_q & out_ready);
    assign accept   = in_valid & in_ready;
    assign load     = accept & ~illegal;

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        vld_d    = vld_q;
        in_ready = 1'b0;
        if (rst_n) begin
            case (state_q)
                EMPTY: in_ready = 1'b1;
                FULL:  in_ready = out_fire;
                default: in_ready = 1'b0;
            endcase
        end
        if (load) begin
            state_d = FULL;
            data_d  = in_data;
            vld_d   = lane;
        end else if (state_q == FULL && out_fire) begin
            state_d = EMPTY;
            vld_d   = 5'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            vld_q   <= 5'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = vld_q;

`ifdef DEMUX15_ILLEGAL_DROP_EN
    logic       err_pulse_q, err_pulse_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_pulse_d = accept & illegal;
        err_cnt_d   = err_cnt_q;
        if (err_pulse_d && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_pulse_q <= 1'b0;
            err_cnt_q   <= 8'h00;
        end else begin
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;
`else
    assign err_pulse = 1'b0;
    assign err_cnt   = 8'h00;
`endif

endmodule
